// File: rtl/io_bus_arbiter.sv
// Round-robin arbiter for the shared tri-state peripheral bus.
// Grants one master at a time and drives bus_en as the peripheral EN.
// Idle turnaround cycles are inserted between owners.
// Unlocked ownership is bounded by a hold timeout.
module io_bus_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned ID_WIDTH = 2,
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned TURN_CYC = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_REQ-1:0]  req,
  input  logic [NUM_REQ-1:0]  lock,
  output logic [NUM_REQ-1:0]  gnt,
  output logic                bus_en,
  output logic [ID_WIDTH-1:0] owner,
  output logic                busy,
  output logic                timeout
);

  localparam int unsigned HOLD_W  = 8;
  localparam int unsigned TURN_W  = 3;
  localparam int unsigned LAST_ID = NUM_REQ - 1;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(MAX_HOLD);
  localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURN_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ID_WIDTH-1:0] rr_q, rr_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [TURN_W-1:0]   turn_q, turn_d;

  logic [NUM_REQ-1:0]  gnt_d;
  logic [ID_WIDTH-1:0] owner_d;
  logic                bus_en_d;
  logic                busy_d;
  logic                timeout_d;

  logic                win_valid;
  logic [ID_WIDTH-1:0] win_id;
  logic [ID_WIDTH-1:0] scan_id;
  logic [ID_WIDTH-1:0] rr_after;

  // Winner: first requesting master scanning upward from rr_q, wrapping at NUM_REQ.
  always_comb begin
    win_valid = 1'b0;
    win_id    = '0;
    scan_id   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (32'(rr_q) + i >= NUM_REQ) begin
        scan_id = ID_WIDTH'(32'(rr_q) + i - NUM_REQ);
      end else begin
        scan_id = ID_WIDTH'(32'(rr_q) + i);
      end
      if (!win_valid && req[scan_id]) begin
        win_valid = 1'b1;
        win_id    = scan_id;
      end
    end
  end

  // Priority pointer after the current owner lets go: the master just above it.
  always_comb begin
    if (32'(owner) == LAST_ID) begin
      rr_after = '0;
    end else begin
      rr_after = owner + ID_WIDTH'(1);
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    hold_d    = hold_q;
    turn_d    = turn_q;
    gnt_d     = gnt;
    owner_d   = owner;
    timeout_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          state_d = ST_GRANT;
          gnt_d   = NUM_REQ'(1) << win_id;
          owner_d = win_id;
          hold_d  = '0;
        end
      end

      ST_GRANT: begin
        if (hold_q != HOLD_SAT) begin
          hold_d = hold_q + HOLD_W'(1);
        end
        if (!req[owner]) begin
          state_d = ST_TURN;
          gnt_d   = '0;
          turn_d  = '0;
          rr_d    = rr_after;
        end else if ((hold_q >= HOLD_LAST) && !lock[owner]) begin
          state_d   = ST_TURN;
          gnt_d     = '0;
          turn_d    = '0;
          rr_d      = rr_after;
          timeout_d = 1'b1;
        end
      end

      ST_TURN: begin
        gnt_d = '0;
        if (turn_q == TURN_LAST) begin
          if (win_valid) begin
            state_d = ST_GRANT;
            gnt_d   = NUM_REQ'(1) << win_id;
            owner_d = win_id;
            hold_d  = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          turn_d = turn_q + TURN_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase

    bus_en_d = |gnt_d;
    busy_d   = (state_d != ST_IDLE);
  end

  // State and registered outputs; reset drops the grant without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rr_q    <= '0;
      hold_q  <= '0;
      turn_q  <= '0;
      gnt     <= '0;
      owner   <= '0;
      bus_en  <= 1'b0;
      busy    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      hold_q  <= hold_d;
      turn_q  <= turn_d;
      gnt     <= gnt_d;
      owner   <= owner_d;
      bus_en  <= bus_en_d;
      busy    <= busy_d;
      timeout <= timeout_d;
    end
  end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Self-checking bench for io_bus_arbiter: vector table, corner sequences,
// and randomized traffic against a behavioural ownership model.
module tb_io_bus_arbiter;

  localparam int NR   = 4;
  localparam int IDW  = 2;
  localparam int MAXH = 16;
  localparam int TURN = 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [NR-1:0]  req = '0;
  logic [NR-1:0]  lock = '0;
  logic [NR-1:0]  gnt;
  logic           bus_en;
  logic [IDW-1:0] owner;
  logic           busy;
  logic           timeout;

  int n_checks = 0;
  int n_errors = 0;

  // Model: current owner (-1 none), cycles held, remaining turnaround cycles,
  // last released owner (priority starts after it), displayed owner, timeout pulse.
  int m_cur, m_held, m_gap, m_last, m_disp;
  bit m_to;

  io_bus_arbiter #(
    .NUM_REQ (NR),
    .ID_WIDTH(IDW),
    .MAX_HOLD(MAXH),
    .TURN_CYC(TURN)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .lock   (lock),
    .gnt    (gnt),
    .bus_en (bus_en),
    .owner  (owner),
    .busy   (busy),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cur  = -1;
    m_held = 0;
    m_gap  = 0;
    m_last = NR - 1;
    m_disp = 0;
    m_to   = 1'b0;
  endtask

  // One clock of the ownership rules, using the inputs the DUT sampled.
  task automatic model_step();
    int c;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_to = 1'b0;
    if (m_cur >= 0) begin
      m_held++;
      if (!req[m_cur]) begin
        m_last = m_cur;
        m_cur  = -1;
        m_gap  = TURN;
      end else if (m_held >= MAXH && !lock[m_cur]) begin
        m_last = m_cur;
        m_cur  = -1;
        m_gap  = TURN;
        m_to   = 1'b1;
      end
    end else if (m_gap > 1) begin
      m_gap--;
    end else begin
      m_gap = 0;
      for (int k = 1; k <= NR; k++) begin
        c = (m_last + k) % NR;
        if (m_cur < 0 && req[c]) begin
          m_cur  = c;
          m_held = 0;
          m_disp = c;
        end
      end
    end
  endtask

  task automatic check_model();
    logic [NR-1:0] eg;
    eg = (m_cur >= 0) ? (NR'(1) << m_cur) : '0;
    check("mdl_gnt", 32'(gnt), 32'(eg));
    check("mdl_bus_en", 32'(bus_en), 32'(m_cur >= 0));
    check("mdl_owner", 32'(owner), 32'(m_disp));
    check("mdl_busy", 32'(busy), 32'((m_cur >= 0) || (m_gap > 0)));
    check("mdl_timeout", 32'(timeout), 32'(m_to));
    check("onehot0_gnt", 32'($onehot0(gnt)), 32'd1);
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    lock  = '0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_grant(input string name);
    int n;
    n = 0;
    while (gnt == '0 && n < 8) begin
      step();
      n++;
    end
    check(name, 32'(gnt != '0), 32'd1);
  endtask

  typedef struct {
    logic [NR-1:0]  req;
    logic [NR-1:0]  gnt;
    logic [IDW-1:0] owner;
    logic           busy;
    logic           timeout;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int cnt;
    int bad;
    int exp;

    tbl[0]  = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
    tbl[1]  = '{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
    tbl[2]  = '{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
    tbl[3]  = '{4'b0000, 4'b0000, 2'd2, 1'b1, 1'b0};
    tbl[4]  = '{4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0};
    tbl[5]  = '{4'b1010, 4'b1000, 2'd3, 1'b1, 1'b0};
    tbl[6]  = '{4'b1010, 4'b1000, 2'd3, 1'b1, 1'b0};
    tbl[7]  = '{4'b0010, 4'b0000, 2'd3, 1'b1, 1'b0};
    tbl[8]  = '{4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0};
    tbl[9]  = '{4'b0011, 4'b0010, 2'd1, 1'b1, 1'b0};
    tbl[10] = '{4'b0001, 4'b0000, 2'd1, 1'b1, 1'b0};
    tbl[11] = '{4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0};
    tbl[12] = '{4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0};
    tbl[13] = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};

    // Reset state, then 20 idle clocks with no timeout pulse.
    do_reset();
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_bus_en", 32'(bus_en), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (timeout || busy || gnt != '0) bad++;
    end
    check("idle20", 32'(bad), 32'd0);

    // Vector table, one clock per row, from fresh reset.
    do_reset();
    for (int i = 0; i < 14; i++) begin
      req = tbl[i].req;
      step();
      check($sformatf("tbl%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
      check($sformatf("tbl%0d_bus_en", i), 32'(bus_en), 32'(tbl[i].gnt != '0));
      check($sformatf("tbl%0d_owner", i), 32'(owner), 32'(tbl[i].owner));
      check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
      check($sformatf("tbl%0d_timeout", i), 32'(timeout), 32'(tbl[i].timeout));
    end

    // Round robin with all requesting, each released after 3 grant cycles.
    do_reset();
    req = 4'hF;
    step();
    for (int g = 0; g < 5; g++) begin
      exp = g % NR;
      check($sformatf("rr%0d_gnt", g), 32'(gnt), 32'(NR'(1) << exp));
      step();
      step();
      req[exp] = 1'b0;
      step();
      check($sformatf("rr%0d_gap", g), 32'({gnt, bus_en}), 32'd0);
      req = 4'hF;
      step();
    end

    // Unlocked hold timeout: exactly MAXH grant cycles, pulse with the fall.
    do_reset();
    req = 4'b0001;
    wait_grant("to_wait");
    cnt = 0;
    while (gnt[0] && cnt < 100) begin
      cnt++;
      step();
    end
    check("to_len", 32'(cnt), 32'(MAXH));
    check("to_pulse", 32'(timeout), 32'd1);
    req = 4'b0011;
    step();
    check("to_next_gnt", 32'(gnt), 32'b0010);
    check("to_pulse_end", 32'(timeout), 32'd0);

    // Locked owner is never timed out; dropping lock revokes on the next edge.
    do_reset();
    req  = 4'b0010;
    lock = 4'b0010;
    wait_grant("lk_wait");
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (gnt != 4'b0010 || timeout) bad++;
    end
    check("lk_hold", 32'(bad), 32'd0);
    lock = 4'b0000;
    step();
    check("lk_revoke_gnt", 32'(gnt), 32'd0);
    check("lk_revoke_to", 32'(timeout), 32'd1);

    // Asynchronous reset mid-grant, then priority restarts at master 0.
    do_reset();
    req = 4'b1000;
    wait_grant("ar_wait");
    check("ar_owner", 32'(owner), 32'd3);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("ar_gnt", 32'(gnt), 32'd0);
    check("ar_bus_en", 32'(bus_en), 32'd0);
    check("ar_busy", 32'(busy), 32'd0);
    req = 4'b1001;
    step();
    step();
    rst_n = 1'b1;
    step();
    check("ar_first_gnt", 32'(gnt), 32'b0001);
    check("ar_first_owner", 32'(owner), 32'd0);

    // Randomized sticky requests and locks against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < NR; b++) begin
        if ($urandom_range(15) == 0) req[b] = ~req[b];
        if ($urandom_range(31) == 0) lock[b] = ~lock[b];
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
